// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the NPC core writeback path.
//   - default register-index and data widths
//   - RV32 load funct3 encodings used by the load extender
package npc_pkg;

  localparam int NPC_ADDR_WIDTH = 5;
  localparam int NPC_DATA_WIDTH = 32;
  localparam int NPC_CNT_WIDTH  = 64;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// load_ext: combinational RV32 load extender.
// Ports:
//   rdata    in  32  raw aligned memory word
//   funct3   in  3   load type
//   offset   in  2   byte address bits [1:0]
//   data     out 32  extended load value (raw word when misaligned/illegal)
//   misalign out 1   misaligned access or illegal funct3
module load_ext
  import npc_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the aligned word.
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend by load type; a bad alignment or unknown funct3 passes the raw word through.
  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      LB:  data = {{24{byte_s[7]}}, byte_s};
      LBU: data = {24'h000000, byte_s};
      LH: begin
        if (offset[0]) begin
          misalign = 1'b1;
        end else begin
          data = {{16{half_s[15]}}, half_s};
        end
      end
      LHU: begin
        if (offset[0]) begin
          misalign = 1'b1;
        end else begin
          data = {16'h0000, half_s};
        end
      end
      LW:      misalign = (offset != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the NPC single-issue core.
// Arbitrates ALU and LSU results (LSU has fixed priority), extends load data,
// registers one register-file write per accepted result and counts retirements.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   alu_valid/ready/rd/data       ALU result channel
//   lsu_valid/ready/rd/rdata/
//   lsu_funct3/lsu_offset         LSU completion channel (rd=0 means store)
//   wb_stall                      blocks new acceptance
//   rf_wen/rf_waddr/rf_wdata      registered register-file write
//   instret                       retired-instruction counter
//   wb_misalign                   pulse alongside a misaligned/illegal load write
module wb_stage
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
  parameter int DATA_WIDTH = NPC_DATA_WIDTH,
  parameter int CNT_WIDTH  = NPC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_offset,
  input  logic                  wb_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  wb_misalign
);

  logic                  lsu_acc_s;
  logic                  alu_acc_s;
  logic                  acc_s;
  logic [ADDR_WIDTH-1:0] rd_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  mis_s;
  logic [DATA_WIDTH-1:0] ext_data_s;
  logic                  ext_mis_s;

  logic                  wen_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [CNT_WIDTH-1:0]  instret_r;
  logic                  mis_r;

  load_ext u_load_ext (
    .rdata    (lsu_rdata),
    .funct3   (lsu_funct3),
    .offset   (lsu_offset),
    .data     (ext_data_s),
    .misalign (ext_mis_s)
  );

  // ALU is held off whenever the LSU presents, so at most one channel accepts.
  assign lsu_ready = rst_n & ~wb_stall;
  assign alu_ready = rst_n & ~wb_stall & ~lsu_valid;
  assign lsu_acc_s = lsu_valid & lsu_ready;
  assign alu_acc_s = alu_valid & alu_ready;
  assign acc_s     = lsu_acc_s | alu_acc_s;

  // Select the accepted result; stores (rd=0) never flag misalignment.
  always_comb begin
    rd_s   = alu_rd;
    data_s = alu_data;
    mis_s  = 1'b0;
    if (lsu_acc_s) begin
      rd_s   = lsu_rd;
      data_s = ext_data_s;
      mis_s  = ext_mis_s & (lsu_rd != {ADDR_WIDTH{1'b0}});
    end else begin
      rd_s   = alu_rd;
      data_s = alu_data;
      mis_s  = 1'b0;
    end
  end

  // Output register and retirement counter; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r     <= 1'b0;
      waddr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      instret_r <= {CNT_WIDTH{1'b0}};
      mis_r     <= 1'b0;
    end else if (acc_s) begin
      wen_r     <= (rd_s != {ADDR_WIDTH{1'b0}});
      waddr_r   <= rd_s;
      wdata_r   <= data_s;
      instret_r <= instret_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      mis_r     <= mis_s;
    end else begin
      wen_r     <= 1'b0;
      mis_r     <= 1'b0;
    end
  end

  assign rf_wen      = wen_r;
  assign rf_waddr    = waddr_r;
  assign rf_wdata    = wdata_r;
  assign instret     = instret_r;
  assign wb_misalign = mis_r;

endmodule
